zoom_scaler: RTL and testbench

Parametrised nearest-neighbour video downscaler for one capture channel, feeding the DDR3 write path.
- Decimates a SRC_W×SRC_H input frame to DST_W×DST_H in both axes with an error-accumulator (DDA) rule.
- Packs kept pixels into 256-bit words and buffers them in a word FIFO.
- Issues burst requests to the HDMI/DDR3 write arbiter, with a frame index (1,2,3) and a burst address.

---
 rtl/zoom_pkg.sv | 31 +++
 rtl/zoom_wfifo.sv | 54 +++++
 rtl/zoom_scaler.sv | 210 +++++++++++++++++++++
 tb/tb_zoom_scaler.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zoom_pkg.sv
// Shared types and the DDA step used by both decimation axes of zoom_scaler.
// dda_step returns {keep, next accumulator} for one accumulate/compare step.
package zoom_pkg;

    localparam int BUS_W  = 256;
    localparam int SLOT_W = 32;
    localparam int DDA_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SEND
    } burst_st_e;

    typedef struct packed {
        logic             keep;
        logic [DDA_W-1:0] acc;
    } dda_t;

    function automatic dda_t dda_step(input logic [DDA_W-1:0] acc,
                                      input logic [DDA_W-1:0] num,
                                      input logic [DDA_W-1:0] den);
        logic [DDA_W-1:0] sum;
        dda_t             res;
        sum      = acc + num;
        res.keep = (sum >= den);
        res.acc  = res.keep ? (sum - den) : sum;
        return res;
    endfunction

endpackage

// File: rtl/zoom_wfifo.sv
// Word FIFO: fall-through read data, occupancy count, synchronous flush.
// A push into a full FIFO is dropped unless a pop frees a slot in the same cycle.
module zoom_wfifo #(
    parameter int DW    = 256,
    parameter int DEPTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     wr_vld_i,
    input  logic [DW-1:0]            wr_dat_i,
    input  logic                     rd_i,
    output logic [DW-1:0]            rd_dat_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     ovf_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          full, rd_ok, wr_ok;

    assign full     = (cnt_q == (AW+1)'(DEPTH));
    assign rd_ok    = rd_i && (cnt_q != '0) && !flush_i;
    assign wr_ok    = wr_vld_i && (!full || rd_ok) && !flush_i;
    assign ovf_o    = wr_vld_i && !wr_ok && !flush_i;
    assign rd_dat_o = mem_q[rptr_q];
    assign count_o  = cnt_q;

    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem_q[wptr_q] <= wr_dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_ok) wptr_q <= wptr_q + 1'b1;
            if (rd_ok) rptr_q <= rptr_q + 1'b1;
            unique case ({wr_ok, rd_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/zoom_scaler.sv
// Nearest-neighbour DDA downscaler: packs kept pixels 8 per 256-bit word into a FIFO
// and hands them to the DDR3 write arbiter in BURST-word grants.
module zoom_scaler
    import zoom_pkg::*;
#(
    parameter int SRC_W      = 960,
    parameter int SRC_H      = 540,
    parameter int DST_W      = 512,
    parameter int DST_H      = 288,
    parameter int PIX_W      = 24,
    parameter int BURST      = 16,
    parameter int FIFO_DEPTH = 64,
    parameter int ADDR_W     = 16
) (
    input  logic              clk_100M,
    input  logic              rst,
    input  logic              din_vs,
    input  logic              din_vld,
    input  logic [PIX_W-1:0]  din,
    output logic [1:0]        ai_frame,
    output logic              ai_req,
    input  logic              ai_rden,
    output logic              ai_vld,
    output logic [BUS_W-1:0]  ai_data,
    output logic [ADDR_W-1:0] ai_addr,
    output logic              ovf
);

    localparam int HAW    = $clog2(2 * SRC_W);
    localparam int VAW    = $clog2(2 * SRC_H);
    localparam int HCW    = $clog2(SRC_W);
    localparam int VCW    = $clog2(SRC_H);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;
    localparam int BW     = $clog2(BURST) + 1;
    localparam int NBURST = (DST_W / 8) * DST_H / BURST;

    logic [HCW-1:0]   hcnt_q, hcnt_d;
    logic [VCW-1:0]   vcnt_q, vcnt_d;
    logic [HAW-1:0]   hacc_q, hacc_d;
    logic [VAW-1:0]   vacc_q, vacc_d;
    logic [2:0]       slot_q, slot_d;
    logic [BUS_W-1:0] word_q, word_d;
    logic             push_vld_q, push_vld_d;
    logic [BUS_W-1:0] push_dat_q, push_dat_d;
    dda_t             hstep, vstep;
    logic             pix_ok, line_end, keep;

    logic             vs_q, flush_pend_q, first_q, ovf_q;
    logic [1:0]       frame_q;
    logic             vs_rise, flush_req, do_flush;

    burst_st_e        state_q, state_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic             pop;

    logic [BUS_W-1:0] fifo_dat;
    logic [CW-1:0]    fifo_cnt;
    logic             fifo_ovf;

    logic             unused_acc_bits;
    assign unused_acc_bits = ^{hstep.acc[DDA_W-1:HAW], vstep.acc[DDA_W-1:VAW]};

    always_comb begin
        hstep      = dda_step(DDA_W'(hacc_q), DDA_W'(DST_W), DDA_W'(SRC_W));
        vstep      = dda_step(DDA_W'(vacc_q), DDA_W'(DST_H), DDA_W'(SRC_H));
        pix_ok     = din_vld && !din_vs;
        line_end   = pix_ok && (hcnt_q == HCW'(SRC_W - 1));
        keep       = pix_ok && hstep.keep && vstep.keep;
        hcnt_d     = hcnt_q;
        vcnt_d     = vcnt_q;
        hacc_d     = hacc_q;
        vacc_d     = vacc_q;
        slot_d     = slot_q;
        word_d     = word_q;
        push_vld_d = 1'b0;
        push_dat_d = push_dat_q;
        if (din_vs) begin
            hcnt_d = '0;
            vcnt_d = '0;
            hacc_d = '0;
            vacc_d = '0;
            slot_d = '0;
            word_d = '0;
        end else if (pix_ok) begin
            hcnt_d = line_end ? '0 : hcnt_q + 1'b1;
            hacc_d = line_end ? '0 : hstep.acc[HAW-1:0];
            // The vertical keep decision for the current line comes from vacc_q.
            if (line_end) begin
                if (vcnt_q == VCW'(SRC_H - 1)) begin
                    vcnt_d = '0;
                    vacc_d = '0;
                end else begin
                    vcnt_d = vcnt_q + 1'b1;
                    vacc_d = vstep.acc[VAW-1:0];
                end
            end
            if (keep) begin
                word_d[slot_q*SLOT_W +: SLOT_W] = SLOT_W'(din);
                slot_d = slot_q + 1'b1;
                if (slot_q == 3'd7) begin
                    push_vld_d = 1'b1;
                    push_dat_d = word_d;
                    word_d     = '0;
                end
            end
        end
    end

    // A frame flush waits for any granted burst to finish before clearing the FIFO.
    assign vs_rise   = din_vs && !vs_q;
    assign flush_req = vs_rise || flush_pend_q;
    assign do_flush  = flush_req && (state_q == IDLE);

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            hcnt_q       <= '0;
            vcnt_q       <= '0;
            hacc_q       <= '0;
            vacc_q       <= '0;
            slot_q       <= '0;
            word_q       <= '0;
            push_vld_q   <= 1'b0;
            push_dat_q   <= '0;
            vs_q         <= 1'b0;
            flush_pend_q <= 1'b0;
            first_q      <= 1'b1;
            frame_q      <= 2'd1;
            ovf_q        <= 1'b0;
        end else begin
            hcnt_q       <= hcnt_d;
            vcnt_q       <= vcnt_d;
            hacc_q       <= hacc_d;
            vacc_q       <= vacc_d;
            slot_q       <= slot_d;
            word_q       <= word_d;
            push_vld_q   <= push_vld_d;
            push_dat_q   <= push_dat_d;
            vs_q         <= din_vs;
            flush_pend_q <= flush_req && !do_flush;
            ovf_q        <= ovf_q || fifo_ovf;
            if (do_flush) begin
                if (first_q) first_q <= 1'b0;
                else         frame_q <= (frame_q == 2'd3) ? 2'd1 : frame_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        ai_req  = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                ai_req = (fifo_cnt >= CW'(BURST)) && !flush_req;
                if (ai_req && ai_rden) state_d = WAIT;
                if (do_flush) addr_d = '0;
            end
            WAIT: begin
                state_d = SEND;
                beat_d  = '0;
            end
            SEND: begin
                pop    = 1'b1;
                beat_d = beat_q + 1'b1;
                if (beat_q == BW'(BURST - 1)) begin
                    state_d = IDLE;
                    addr_d  = (addr_q == ADDR_W'(NBURST - 1)) ? '0 : addr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    zoom_wfifo #(
        .DW    (BUS_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wfifo (
        .clk_i    (clk_100M),
        .rst_i    (rst),
        .flush_i  (do_flush),
        .wr_vld_i (push_vld_q),
        .wr_dat_i (push_dat_q),
        .rd_i     (pop),
        .rd_dat_o (fifo_dat),
        .count_o  (fifo_cnt),
        .ovf_o    (fifo_ovf)
    );

    assign ai_vld   = pop;
    assign ai_data  = pop ? fifo_dat : '0;
    assign ai_addr  = addr_q;
    assign ai_frame = frame_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_zoom_scaler.sv
// Scoreboard bench for zoom_scaler on a reduced 120x30 -> 64x16 frame (same 8/15 ratio).
// Expected words come from a closed-form keep rule and are checked as the arbiter drains them.
module tb_zoom_scaler;

    localparam int SRC_W  = 120;
    localparam int SRC_H  = 30;
    localparam int DST_W  = 64;
    localparam int DST_H  = 16;
    localparam int PIX_W  = 24;
    localparam int BURST  = 16;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 16;
    localparam int NB     = (DST_W / 8) * DST_H / BURST;

    logic              clk_100M = 1'b0;
    logic              rst = 1'b1;
    logic              din_vs = 1'b0;
    logic              din_vld = 1'b0;
    logic [PIX_W-1:0]  din = '0;
    logic              man_rden = 1'b0;
    logic              auto_rden = 1'b0;
    logic              auto_en = 1'b0;
    logic              ai_rden;
    logic [1:0]        ai_frame;
    logic              ai_req;
    logic              ai_vld;
    logic [255:0]      ai_data;
    logic [ADDR_W-1:0] ai_addr;
    logic              ovf;

    assign ai_rden = man_rden | auto_rden;

    always #5 clk_100M = ~clk_100M;

    zoom_scaler #(
        .SRC_W(SRC_W), .SRC_H(SRC_H), .DST_W(DST_W), .DST_H(DST_H),
        .PIX_W(PIX_W), .BURST(BURST), .FIFO_DEPTH(DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .clk_100M (clk_100M),
        .rst      (rst),
        .din_vs   (din_vs),
        .din_vld  (din_vld),
        .din      (din),
        .ai_frame (ai_frame),
        .ai_req   (ai_req),
        .ai_rden  (ai_rden),
        .ai_vld   (ai_vld),
        .ai_data  (ai_data),
        .ai_addr  (ai_addr),
        .ovf      (ovf)
    );

    int           vectors = 0;
    int           miscompares = 0;
    logic [255:0] exp_q[$];
    logic [255:0] exp_w;
    logic [255:0] first_word = '0;
    bit           got_first = 1'b0;
    int           pop_cnt = 0;
    int           pop_base = 0;
    int           last_addr = 0;
    logic [31:0]  slots[8];
    int           slot_n = 0;
    int           kept_in_line = 0;
    int           tbl[8] = '{1, 3, 5, 7, 9, 11, 13, 14};

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit hk(input int x);
        return (((x + 1) * DST_W) / SRC_W) != ((x * DST_W) / SRC_W);
    endfunction

    function automatic bit vk(input int y);
        return (((y + 1) * DST_H) / SRC_H) != ((y * DST_H) / SRC_H);
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_100M);
            #1;
        end
    endtask

    task automatic model_pix(input int y, input int x);
        logic [255:0] w;
        if (hk(x) && vk(y)) begin
            slots[slot_n] = 32'(y * SRC_W + x);
            slot_n++;
            kept_in_line++;
            if (slot_n == 8) begin
                for (int k = 0; k < 8; k++) w[k*32 +: 32] = slots[k];
                if (exp_q.size() < DEPTH) exp_q.push_back(w);
                slot_n = 0;
            end
        end
    endtask

    task automatic send_pix(input int y, input int x);
        if ($urandom_range(0, 3) == 0) begin
            din_vld = 1'b0;
            step(1);
        end
        din_vld = 1'b1;
        din     = PIX_W'(y * SRC_W + x);
        model_pix(y, x);
        step(1);
    endtask

    task automatic send_lines(input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = 0; x < SRC_W; x++) send_pix(y, x);
        din_vld = 1'b0;
    endtask

    task automatic vs_pulse();
        step(3);
        din_vs = 1'b1;
        step(2);
        din_vs = 1'b0;
        exp_q.delete();
        slot_n   = 0;
        pop_base = pop_cnt;
        step(3);
    endtask

    task automatic grant();
        int i;
        for (i = 0; i < 300; i++) begin
            if (ai_req) break;
            step(1);
        end
        if (i == 300) chk("req_timeout", 256'(ai_req), 256'(1));
        man_rden = 1'b1;
        step(1);
        man_rden = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0 && !ai_vld) break;
            step(1);
        end
        chk("drain_left", 256'(exp_q.size()), 256'(0));
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk_100M);
            if (ai_vld) begin
                if (exp_q.size() == 0) begin
                    chk("word_underflow", 256'(exp_q.size()), 256'(1));
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("word", ai_data, exp_w);
                end
                chk("burst_addr", 256'(ai_addr), 256'(((pop_cnt - pop_base) / BURST) % NB));
                if (!got_first) begin
                    first_word = ai_data;
                    got_first  = 1'b1;
                end
                last_addr = int'(ai_addr);
                pop_cnt++;
            end
        end
    endtask

    task automatic arbiter();
        forever begin
            @(posedge clk_100M);
            #1;
            auto_rden = auto_en && ai_req && !auto_rden;
        end
    endtask

    initial begin
        int x;
        int n;
        fork
            monitor();
            arbiter();
        join_none

        step(3);
        rst = 1'b0;
        chk("rst_frame", 256'(ai_frame), 256'(1));
        chk("rst_req", 256'(ai_req), 256'(0));
        chk("rst_vld", 256'(ai_vld), 256'(0));
        chk("rst_data", ai_data, 256'(0));
        chk("rst_addr", 256'(ai_addr), 256'(0));
        chk("rst_ovf", 256'(ovf), 256'(0));

        // First vs after reset keeps frame 1; one burst with exact grant timing.
        vs_pulse();
        chk("frame_first_vs", 256'(ai_frame), 256'(1));
        send_lines(0, 3);
        step(4);
        grant();
        chk("req_t1", 256'(ai_req), 256'(0));
        chk("vld_t1", 256'(ai_vld), 256'(0));
        for (int i = 0; i < BURST; i++) begin
            step(1);
            chk("burst_vld", 256'(ai_vld), 256'(1));
            chk("burst_addr_hold", 256'(ai_addr), 256'(0));
            chk("burst_frame", 256'(ai_frame), 256'(1));
        end
        step(1);
        chk("vld_after_burst", 256'(ai_vld), 256'(0));
        chk("addr_after_burst", 256'(ai_addr), 256'(1));
        for (int k = 0; k < 8; k++)
            chk("first_word_slot", 256'(first_word[k*32 +: 32]), 256'(SRC_W + tbl[k]));

        // Rest of the frame with a responsive arbiter.
        auto_en = 1'b1;
        send_lines(4, SRC_H - 1);
        wait_drain();
        chk("frame_words", 256'(pop_cnt), 256'((DST_W / 8) * DST_H));
        chk("last_addr", 256'(last_addr), 256'(NB - 1));
        chk("no_ovf", 256'(ovf), 256'(0));
        auto_en = 1'b0;
        step(5);

        // Overflow: no grants for a whole frame, then drain one burst.
        vs_pulse();
        chk("frame_second_vs", 256'(ai_frame), 256'(2));
        send_lines(0, SRC_H - 1);
        step(5);
        chk("ovf_set", 256'(ovf), 256'(1));
        chk("ovf_req", 256'(ai_req), 256'(1));
        grant();
        step(BURST + 4);
        chk("ovf_drained", 256'(pop_cnt - pop_base), 256'(BURST));
        chk("ovf_req_left", 256'(ai_req), 256'(1));

        // vs flushes the FIFO, then a mid-line vs discards a partial word.
        vs_pulse();
        chk("frame_third_vs", 256'(ai_frame), 256'(3));
        chk("flush_req", 256'(ai_req), 256'(0));
        chk("flush_addr", 256'(ai_addr), 256'(0));
        chk("ovf_sticky", 256'(ovf), 256'(1));
        send_lines(0, 0);
        kept_in_line = 0;
        x = 0;
        while (kept_in_line < 29) begin
            send_pix(1, x);
            x++;
        end
        din_vld = 1'b0;
        step(4);
        chk("partial_req", 256'(ai_req), 256'(0));
        vs_pulse();
        chk("frame_wrap", 256'(ai_frame), 256'(1));
        chk("wrap_addr", 256'(ai_addr), 256'(0));
        send_lines(0, 3);
        step(4);
        grant();
        wait_drain();

        // Reset during the 8th beat of the second burst.
        vs_pulse();
        chk("frame_pre_rst", 256'(ai_frame), 256'(2));
        send_lines(0, 7);
        step(4);
        grant();
        step(BURST + 2);
        grant();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (ai_vld) n++;
            if (n == 8) break;
        end
        chk("vld_beats_before_rst", 256'(n), 256'(8));
        rst = 1'b1;
        step(1);
        chk("mid_rst_vld", 256'(ai_vld), 256'(0));
        chk("mid_rst_req", 256'(ai_req), 256'(0));
        chk("mid_rst_addr", 256'(ai_addr), 256'(0));
        chk("mid_rst_frame", 256'(ai_frame), 256'(1));
        chk("mid_rst_ovf", 256'(ovf), 256'(0));
        chk("mid_rst_data", ai_data, 256'(0));
        rst = 1'b0;
        exp_q.delete();
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
